soc_region_decoder: RTL and testbench

//   Runtime-programmable address-region decoder for the SoC interconnect/PMA path. Holds NrRules
//   {base, length, attribute} entries, reset-loaded from parameters. Each rule can be rewritten

---
 rtl/soc_region_decoder_if.sv | 50 +++++
 rtl/soc_region_decoder.sv | 147 ++++++++++++++
 tb/tb_soc_region_decoder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_region_decoder_if.sv
// Bus bundle for the region decoder: rule-table config port plus the
// valid/ready lookup request and response channels.
interface soc_region_decoder_if #(
  parameter int AddrWidth = 64,
  parameter int IdxWidth  = 3
);

  logic                 cfg_we_i;
  logic [IdxWidth-1:0]  cfg_idx_i;
  logic [AddrWidth-1:0] cfg_base_i;
  logic [AddrWidth-1:0] cfg_len_i;
  logic [3:0]           cfg_attr_i;
  logic                 cfg_lock_i;
  logic                 cfg_err_o;
  logic                 locked_o;

  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;

  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic                 rsp_hit_o;
  logic                 rsp_multi_o;
  logic [IdxWidth-1:0]  rsp_idx_o;
  logic                 rsp_cached_o;
  logic                 rsp_exec_o;
  logic                 rsp_nonidem_o;

  modport master (
    output cfg_we_i, cfg_idx_i, cfg_base_i, cfg_len_i, cfg_attr_i, cfg_lock_i,
    input  cfg_err_o, locked_o,
    output req_valid_i, req_addr_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_hit_o, rsp_multi_o, rsp_idx_o,
    input  rsp_cached_o, rsp_exec_o, rsp_nonidem_o,
    output rsp_ready_i
  );

  modport slave (
    input  cfg_we_i, cfg_idx_i, cfg_base_i, cfg_len_i, cfg_attr_i, cfg_lock_i,
    output cfg_err_o, locked_o,
    input  req_valid_i, req_addr_i,
    output req_ready_o,
    output rsp_valid_o, rsp_hit_o, rsp_multi_o, rsp_idx_o,
    output rsp_cached_o, rsp_exec_o, rsp_nonidem_o,
    input  rsp_ready_i
  );

endinterface

// File: rtl/soc_region_decoder.sv
// Programmable address-region decoder: a lockable table of {base,len,attr}
// rules looked up through a single registered valid/ready output stage.
module soc_region_decoder #(
  parameter int NrRules   = 8,
  parameter int AddrWidth = 64,
  parameter int IdxWidth  = (NrRules > 1) ? $clog2(NrRules) : 1,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase   = '{default: '0},
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstLength = '{default: '0},
  parameter logic [NrRules-1:0][3:0]           RstAttr   = '{default: '0}
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  soc_region_decoder_if.slave bus
);

  localparam int AttrValid   = 3;
  localparam int AttrCached  = 2;
  localparam int AttrExec    = 1;
  localparam int AttrNonidem = 0;

  logic                    r_locked;
  logic                    r_cfg_err;
  logic                    w_cfg_idx_ok;
  logic                    w_cfg_commit;

  logic [NrRules-1:0]      w_wr_sel;
  logic [NrRules-1:0]      w_match;
  logic [NrRules-1:0][3:0] w_attr;

  logic                    w_hit;
  logic                    w_multi;
  logic [IdxWidth-1:0]     w_win_idx;
  logic [3:0]              w_win_attr;

  logic                    w_req_ready;
  logic                    w_accept;

  logic                    r_rsp_valid;
  logic                    r_rsp_hit;
  logic                    r_rsp_multi;
  logic [IdxWidth-1:0]     r_rsp_idx;
  logic                    r_rsp_cached;
  logic                    r_rsp_exec;
  logic                    r_rsp_nonidem;

  // Out-of-range indices are rejected here so no rule select ever decodes them.
  assign w_cfg_idx_ok = (int'(bus.cfg_idx_i) < NrRules);
  assign w_cfg_commit = bus.cfg_we_i && !r_locked && w_cfg_idx_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_locked  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_locked  <= r_locked | bus.cfg_lock_i;
      r_cfg_err <= bus.cfg_we_i && !w_cfg_commit;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NrRules; gi++) begin : g_rule
      logic [AddrWidth-1:0] r_base;
      logic [AddrWidth-1:0] r_len;
      logic [3:0]           r_attr;
      logic [AddrWidth:0]   w_end;

      assign w_wr_sel[gi] = w_cfg_commit && (bus.cfg_idx_i == IdxWidth'(gi));

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_base <= RstBase[gi];
          r_len  <= RstLength[gi];
          r_attr <= RstAttr[gi];
        end else if (w_wr_sel[gi]) begin
          r_base <= bus.cfg_base_i;
          r_len  <= bus.cfg_len_i;
          r_attr <= bus.cfg_attr_i;
        end
      end

      // One extra bit lets a region end exactly at 2^AddrWidth without wrapping.
      assign w_end = {1'b0, r_base} + {1'b0, r_len};

      assign w_match[gi] = r_attr[AttrValid]
                        && (r_len != '0)
                        && (bus.req_addr_i >= r_base)
                        && ({1'b0, bus.req_addr_i} < w_end);

      assign w_attr[gi] = r_attr;
    end
  endgenerate

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    w_hit      = 1'b0;
    w_win_idx  = '0;
    w_win_attr = '0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit      = 1'b1;
        w_win_idx  = IdxWidth'(i);
        w_win_attr = w_attr[i];
      end
    end
  end

  assign w_multi = |(w_match & (w_match - NrRules'(1)));

  assign w_req_ready = !r_rsp_valid || bus.rsp_ready_i;
  assign w_accept    = bus.req_valid_i && w_req_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_hit     <= 1'b0;
      r_rsp_multi   <= 1'b0;
      r_rsp_idx     <= '0;
      r_rsp_cached  <= 1'b0;
      r_rsp_exec    <= 1'b0;
      r_rsp_nonidem <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_hit     <= w_hit;
      r_rsp_multi   <= w_multi;
      r_rsp_idx     <= w_win_idx;
      r_rsp_cached  <= w_hit && w_win_attr[AttrCached];
      r_rsp_exec    <= w_hit && w_win_attr[AttrExec];
      // An unmapped address is treated as having side effects on access.
      r_rsp_nonidem <= !w_hit || w_win_attr[AttrNonidem];
    end else if (bus.rsp_ready_i) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  assign bus.cfg_err_o     = r_cfg_err;
  assign bus.locked_o      = r_locked;
  assign bus.req_ready_o   = w_req_ready;
  assign bus.rsp_valid_o   = r_rsp_valid;
  assign bus.rsp_hit_o     = r_rsp_hit;
  assign bus.rsp_multi_o   = r_rsp_multi;
  assign bus.rsp_idx_o     = r_rsp_idx;
  assign bus.rsp_cached_o  = r_rsp_cached;
  assign bus.rsp_exec_o    = r_rsp_exec;
  assign bus.rsp_nonidem_o = r_rsp_nonidem;

endmodule

// File: tb/tb_soc_region_decoder.sv
// Scoreboard bench for soc_region_decoder: directed lookups, config writes,
// lock, backpressure and mid-transaction reset.
module tb_soc_region_decoder;

  localparam int NR = 6;
  localparam int AW = 64;
  localparam int IW = 3;

  localparam logic [NR-1:0][AW-1:0] RST_BASE =
    {64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0000};
  localparam logic [NR-1:0][AW-1:0] RST_LEN =
    {64'h0, 64'h0, 64'h0, 64'h0, 64'h1000, 64'h2000_0000};
  localparam logic [NR-1:0][3:0] RST_ATTR =
    {4'h0, 4'h0, 4'h0, 4'h0, 4'b1011, 4'b1110};

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          hit;
    logic          multi;
    logic [IW-1:0] idx;
    logic          cached;
    logic          exec;
    logic          nonidem;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  soc_region_decoder_if #(.AddrWidth(AW), .IdxWidth(IW)) bus ();

  soc_region_decoder #(
    .NrRules  (NR),
    .AddrWidth(AW),
    .RstBase  (RST_BASE),
    .RstLength(RST_LEN),
    .RstAttr  (RST_ATTR)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [AW-1:0] a, input logic h, input logic m,
                              input logic [IW-1:0] i, input logic c, input logic x,
                              input logic n);
    exp_t e;
    e.addr = a; e.hit = h; e.multi = m; e.idx = i;
    e.cached = c; e.exec = x; e.nonidem = n;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input exp_t e);
    bit done = 0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = e.addr;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk_i);
      if (bus.req_ready_o) begin
        sb_q.push_back(e);
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout addr=%0h actual=not_accepted required=accepted", e.addr);
    end
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic cfg_write(input logic [IW-1:0] idx, input logic [AW-1:0] base,
                           input logic [AW-1:0] len, input logic [3:0] attr);
    bus.cfg_we_i   = 1'b1;
    bus.cfg_idx_i  = idx;
    bus.cfg_base_i = base;
    bus.cfg_len_i  = len;
    bus.cfg_attr_i = attr;
    @(posedge clk_i); #1;
    bus.cfg_we_i   = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60; t++) begin
      @(posedge clk_i); #2;
      if (sb_q.size() == 0) break;
    end
    chk("drain_empty", AW'(sb_q.size()), 0);
    @(posedge clk_i); #1;
  endtask

  // Monitor: pop on every handshake, and require held data under backpressure.
  initial begin
    logic [IW+4:0] prev, cur;
    bit            have_prev;
    exp_t          e;
    have_prev = 0;
    prev      = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        have_prev = 0;
      end else if (bus.rsp_valid_o) begin
        cur = {bus.rsp_hit_o, bus.rsp_multi_o, bus.rsp_idx_o,
               bus.rsp_cached_o, bus.rsp_exec_o, bus.rsp_nonidem_o};
        if (have_prev) chk("rsp_hold", AW'(cur), AW'(prev));
        if (bus.rsp_ready_i) begin
          have_prev = 0;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual=%0h required=none", cur);
          end else begin
            e = sb_q.pop_front();
            $display("rsp addr=%0h hit=%0d multi=%0d idx=%0d c=%0d x=%0d n=%0d",
                     e.addr, bus.rsp_hit_o, bus.rsp_multi_o, bus.rsp_idx_o,
                     bus.rsp_cached_o, bus.rsp_exec_o, bus.rsp_nonidem_o);
            chk($sformatf("rsp_%0h", e.addr), AW'(cur),
                AW'({e.hit, e.multi, e.idx, e.cached, e.exec, e.nonidem}));
          end
        end else begin
          prev      = cur;
          have_prev = 1;
        end
      end
    end
  end

  initial begin
    bus.cfg_we_i    = 1'b0;
    bus.cfg_idx_i   = '0;
    bus.cfg_base_i  = '0;
    bus.cfg_len_i   = '0;
    bus.cfg_attr_i  = '0;
    bus.cfg_lock_i  = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.rsp_ready_i = 1'b1;
    rst_ni          = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    chk("rst_rsp_valid", AW'(bus.rsp_valid_o), 0);
    chk("rst_locked", AW'(bus.locked_o), 0);
    chk("rst_cfg_err", AW'(bus.cfg_err_o), 0);
    chk("rst_req_ready", AW'(bus.req_ready_o), 1);
    chk("rst_rsp_hit", AW'(bus.rsp_hit_o), 0);
    chk("rst_rsp_nonidem", AW'(bus.rsp_nonidem_o), 0);

    send(mk(64'h8000_0000, 1, 0, 0, 1, 1, 0));
    chk("latency_valid", AW'(bus.rsp_valid_o), 1);
    send(mk(64'h9FFF_FFFF, 1, 0, 0, 1, 1, 0));
    send(mk(64'hA000_0000, 0, 0, 0, 0, 0, 1));
    send(mk(64'h0000_0FFF, 1, 0, 1, 0, 1, 1));
    send(mk(64'h0000_1000, 0, 0, 0, 0, 0, 1));
    drain();

    cfg_write(3, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 4'b1000);
    chk("wr3_cfg_err", AW'(bus.cfg_err_o), 0);
    send(mk(64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 3, 0, 0, 0));
    send(mk(64'hFFFF_FFFF_FFFF_EFFF, 0, 0, 0, 0, 0, 1));

    cfg_write(2, 64'h8000_0000, 64'h100, 4'b1000);
    send(mk(64'h8000_0010, 1, 1, 0, 1, 1, 0));
    send(mk(64'h8000_0100, 1, 0, 0, 1, 1, 0));
    drain();

    // Write and lookup in the same cycle: lookup must see the old table.
    bus.cfg_we_i    = 1'b1;
    bus.cfg_idx_i   = 3'd4;
    bus.cfg_base_i  = 64'h2000;
    bus.cfg_len_i   = 64'h100;
    bus.cfg_attr_i  = 4'b1100;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'h2000;
    @(negedge clk_i);
    chk("samecyc_ready", AW'(bus.req_ready_o), 1);
    sb_q.push_back(mk(64'h2000, 0, 0, 0, 0, 0, 1));
    @(posedge clk_i); #1;
    bus.cfg_we_i    = 1'b0;
    bus.req_valid_i = 1'b0;
    send(mk(64'h2000, 1, 0, 4, 1, 0, 0));
    drain();

    bus.rsp_ready_i = 1'b0;
    fork
      begin
        send(mk(64'h8000_0000, 1, 1, 0, 1, 1, 0));
        send(mk(64'hA000_0000, 0, 0, 0, 0, 0, 1));
        send(mk(64'h0000_0010, 1, 0, 1, 0, 1, 1));
        send(mk(64'h0000_1000, 0, 0, 0, 0, 0, 1));
      end
      begin
        for (int t = 0; t < 20; t++) begin
          @(negedge clk_i);
          if (bus.rsp_valid_o) break;
        end
        chk("bp_valid", AW'(bus.rsp_valid_o), 1);
        chk("bp_ready0", AW'(bus.req_ready_o), 0);
        @(negedge clk_i);
        chk("bp_ready1", AW'(bus.req_ready_o), 0);
        @(negedge clk_i);
        chk("bp_ready2", AW'(bus.req_ready_o), 0);
        @(posedge clk_i); #1;
        bus.rsp_ready_i = 1'b1;
      end
    join
    drain();

    cfg_write(3'd6, 64'h0, 64'h10, 4'b1000);
    chk("badidx_err", AW'(bus.cfg_err_o), 1);
    @(posedge clk_i); #1;
    chk("badidx_err_clr", AW'(bus.cfg_err_o), 0);

    bus.cfg_lock_i = 1'b1;
    @(posedge clk_i); #1;
    bus.cfg_lock_i = 1'b0;
    chk("locked_set", AW'(bus.locked_o), 1);
    cfg_write(0, 64'h8000_0000, 64'h0, 4'b1110);
    chk("locked_err", AW'(bus.cfg_err_o), 1);
    @(posedge clk_i); #1;
    chk("locked_err_clr", AW'(bus.cfg_err_o), 0);
    send(mk(64'h8000_0000, 1, 1, 0, 1, 1, 0));
    drain();
    chk("locked_sticky", AW'(bus.locked_o), 1);

    bus.rsp_ready_i = 1'b0;
    send(mk(64'h8000_0010, 1, 1, 0, 1, 1, 0));
    chk("pre_rst_valid", AW'(bus.rsp_valid_o), 1);
    #3 rst_ni = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_rst_valid", AW'(bus.rsp_valid_o), 0);
    chk("mid_rst_locked", AW'(bus.locked_o), 0);
    chk("mid_rst_hit", AW'(bus.rsp_hit_o), 0);
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;

    send(mk(64'h8000_0010, 1, 0, 0, 1, 1, 0));
    send(mk(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 1));
    send(mk(64'h2000, 0, 0, 0, 0, 0, 1));
    send(mk(64'h0, 1, 0, 1, 0, 1, 1));
    cfg_write(0, 64'h4000, 64'h10, 4'b1001);
    chk("post_rst_wr_err", AW'(bus.cfg_err_o), 0);
    send(mk(64'h4008, 1, 0, 0, 0, 0, 1));
    send(mk(64'h8000_0000, 0, 0, 0, 0, 0, 1));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
